// File: rtl/uart_core_pkg.sv
// uart_core_pkg: shared constants, FSM state encoding and baud divider helper
package uart_core_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  function automatic int calc_div(longint clk_freq, longint baud, longint os);
    longint d;
    d = (2 * clk_freq + baud * os) / (2 * baud * os);
    return d < 1 ? 1 : int'(d);
  endfunction
endpackage

// File: rtl/uart_core_sync_fifo.sv
// sync_fifo: synchronous first-word fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with RX/TX FIFOs and per-byte error flags
module uart_core
  import uart_core_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 err_clear,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     tx_count,
  output logic [FIFO_AW:0]     rx_count
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic ODD = PARITY == PARITY_ODD;
  localparam bit HAS_PAR = PARITY != PARITY_NONE;
  logic [CW-1:0] div_cnt;
  logic tick;
  assign tick = div_cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    div_cnt <= rst || tick ? '0 : div_cnt + 1'b1;
  // rs2 is the synchronized line, rs3 its previous value for edge detection
  logic rs1, rs2, rs3;
  always_ff @(posedge clk)
    {rs1, rs2, rs3} <= rst ? 3'b111 : {rxd, rs1, rs2};
  state_t rx_state, rx_state_n;
  logic [TW-1:0] rx_tc, rx_tc_n;
  logic [BW-1:0] rx_bc, rx_bc_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic rx_perr, rx_perr_n, rx_ferr, rx_ferr_n, rx_push, rx_push_n, rx_sample;
  assign rx_sample = tick && rx_tc == (rx_state == S_START ? TW'(OVERSAMPLE/2 - 1) : TW'(OVERSAMPLE - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_tc <= '0;
      rx_bc <= '0;
      rx_sh <= '0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      rx_push <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tc <= rx_tc_n;
      rx_bc <= rx_bc_n;
      rx_sh <= rx_sh_n;
      rx_perr <= rx_perr_n;
      rx_ferr <= rx_ferr_n;
      rx_push <= rx_push_n;
    end
  end
  always_comb begin
    rx_state_n = rx_state;
    rx_tc_n = rx_sample ? '0 : tick ? rx_tc + 1'b1 : rx_tc;
    rx_bc_n = rx_bc;
    rx_sh_n = rx_sh;
    rx_perr_n = rx_perr;
    rx_ferr_n = rx_ferr;
    rx_push_n = 1'b0;
    case (rx_state)
      S_IDLE: if (rs3 && !rs2) begin
        rx_state_n = S_START;
        rx_tc_n = '0;
      end
      S_START: if (rx_sample) begin
        rx_state_n = rs2 ? S_IDLE : S_DATA;
        rx_bc_n = '0;
        rx_perr_n = 1'b0;
      end
      S_DATA: if (rx_sample) begin
        rx_sh_n = {rs2, rx_sh[DATA_BITS-1:1]};
        rx_bc_n = rx_bc + 1'b1;
        if (rx_bc == BW'(DATA_BITS - 1)) rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_sample) begin
        rx_perr_n = rs2 != (^rx_sh ^ ODD);
        rx_state_n = S_STOP;
      end
      S_STOP: if (rx_sample) begin
        rx_ferr_n = !rs2;
        rx_push_n = 1'b1;
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end
  logic rx_full, rx_empty;
  sync_fifo #(.WIDTH(DATA_BITS + 2), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din({rx_perr, rx_ferr, rx_sh}), .pop(rx_ready),
    .dout({rx_parity_err, rx_frame_err, rx_data}), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  assign rx_valid = !rx_empty;
  always_ff @(posedge clk)
    if (rst || err_clear) rx_overrun <= 1'b0;
    else if (rx_push && rx_full) rx_overrun <= 1'b1;
  state_t tx_state, tx_state_n;
  logic [TW-1:0] tx_tc, tx_tc_n;
  logic [BW-1:0] tx_bc, tx_bc_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n, tx_head;
  logic tx_par, tx_par_n, txd_n, tx_end, tx_load, tx_full, tx_empty;
  assign tx_end = tick && tx_tc == TW'(OVERSAMPLE - 1);
  // next frame starts straight out of the last stop bit, so queued bytes leave no gap
  assign tx_load = !tx_empty && tick &&
    (tx_state == S_IDLE || (tx_state == S_STOP && tx_end && tx_bc == BW'(STOP_BITS - 1)));
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_tc <= '0;
      tx_bc <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tc <= tx_tc_n;
      tx_bc <= tx_bc_n;
      tx_sh <= tx_sh_n;
      tx_par <= tx_par_n;
      txd <= txd_n;
    end
  end
  always_comb begin
    tx_state_n = tx_state;
    tx_tc_n = tx_end ? '0 : tick ? tx_tc + 1'b1 : tx_tc;
    tx_bc_n = tx_bc;
    tx_sh_n = tx_sh;
    tx_par_n = tx_par;
    txd_n = txd;
    case (tx_state)
      S_IDLE: txd_n = 1'b1;
      S_START: if (tx_end) begin
        tx_state_n = S_DATA;
        tx_bc_n = '0;
        txd_n = tx_sh[0];
      end
      S_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        tx_bc_n = tx_bc + 1'b1;
        txd_n = tx_sh[1];
        if (tx_bc == BW'(DATA_BITS - 1)) begin
          tx_bc_n = '0;
          tx_state_n = HAS_PAR ? S_PARITY : S_STOP;
          txd_n = HAS_PAR ? tx_par : 1'b1;
        end
      end
      S_PARITY: if (tx_end) begin
        tx_state_n = S_STOP;
        tx_bc_n = '0;
        txd_n = 1'b1;
      end
      S_STOP: if (tx_end) begin
        tx_bc_n = tx_bc + 1'b1;
        if (tx_bc == BW'(STOP_BITS - 1)) tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load) begin
      tx_state_n = S_START;
      tx_tc_n = '0;
      tx_sh_n = tx_head;
      tx_par_n = ^tx_head ^ ODD;
      txd_n = 1'b0;
    end
  end
  sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .din(tx_data), .pop(tx_load),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  assign tx_ready = !tx_full;
  assign tx_busy = !tx_empty || tx_state != S_IDLE;
endmodule
